// File: rtl/spi_fifo_pkg.sv
// Shared SPI peripheral types and sizing constants used by the FIFO and
// the APB register block.
package spi_fifo_pkg;

    localparam int SPI_DATA_WIDTH    = 32;
    localparam int SPI_POINTER_WIDTH = 6;
    localparam int SPI_FIFO_DEPTH    = 2 ** SPI_POINTER_WIDTH;

    typedef logic [SPI_DATA_WIDTH-1:0] bus;

    typedef struct packed {
        logic fifo_full;
        logic fifo_empty;
        logic fifo_overflow;
        logic fifo_underflow;
    } fifo_interrupt;

endpackage

// File: rtl/spi_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy and sticky
// overflow/underflow flags, used for both the SPI TX and RX paths.
module spi_fifo
    import spi_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = SPI_DATA_WIDTH,
    parameter int POINTER_WIDTH = SPI_POINTER_WIDTH
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     wen,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     ren,
    output logic [DATA_WIDTH-1:0]    rdata,
    input  logic                     clear,
    output logic [POINTER_WIDTH:0]   level,
    output fifo_interrupt            fifo_int
);

    localparam int DEPTH = 2 ** POINTER_WIDTH;
    localparam logic [POINTER_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [POINTER_WIDTH:0] wptr_q, wptr_d;
    logic [POINTER_WIDTH:0] rptr_q, rptr_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic                   do_push, do_pop;

    // A pop from a full FIFO frees the slot the simultaneous push lands in.
    always_comb begin
        do_pop      = ren && !empty_q;
        do_push     = wen && (!full_q || do_pop);
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            do_pop      = 1'b0;
            do_push     = 1'b0;
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (do_push)         wptr_d      = wptr_q + PTR_ONE;
            if (do_pop)          rptr_d      = rptr_q + PTR_ONE;
            if (wen && !do_push) overflow_d  = 1'b1;
            if (ren && empty_q)  underflow_d = 1'b1;
        end
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[POINTER_WIDTH-1:0] == rptr_d[POINTER_WIDTH-1:0]) &&
                  (wptr_d[POINTER_WIDTH] != rptr_d[POINTER_WIDTH]);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge pclk) begin
        if (!preset && do_push) begin
            mem_q[wptr_q[POINTER_WIDTH-1:0]] <= wdata;
        end
    end

    assign rdata    = mem_q[rptr_q[POINTER_WIDTH-1:0]];
    assign level    = wptr_q - rptr_q;
    assign fifo_int = '{fifo_full:      full_q,
                        fifo_empty:     empty_q,
                        fifo_overflow:  overflow_q,
                        fifo_underflow: underflow_q};

endmodule

// File: tb/tb_spi_fifo.sv
// Scoreboard bench for spi_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_spi_fifo;
    import spi_fifo_pkg::*;

    localparam int DW    = SPI_DATA_WIDTH;
    localparam int PW    = SPI_POINTER_WIDTH;
    localparam int DEPTH = SPI_FIFO_DEPTH;

    logic          pclk;
    logic          preset;
    logic          wen;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [DW-1:0] rdata;
    logic          clear;
    logic [PW:0]   level;
    fifo_interrupt fifo_int;

    spi_fifo dut (
        .pclk     (pclk),
        .preset   (preset),
        .wen      (wen),
        .wdata    (wdata),
        .ren      (ren),
        .rdata    (rdata),
        .clear    (clear),
        .level    (level),
        .fifo_int (fifo_int)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: occupancy, sticky flags, and the queue of expected words.
    int            m_count = 0;
    bit            m_ovf   = 1'b0;
    bit            m_unf   = 1'b0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop presents a word that must match the scoreboard head.
    always @(negedge pclk) begin
        if (!preset && !clear && ren && !fifo_int.fifo_empty) begin
            if (exp_q.size() == 0) begin
                check("pop_without_expected_word", 64'd1, 64'd0);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                check("pop_data", 64'(rdata), 64'(e));
            end
        end
    end

    task automatic step(input bit w, input logic [DW-1:0] wd, input bit r, input bit c);
        bit pop_ok, push_ok;
        wen   = w;
        wdata = wd;
        ren   = r;
        clear = c;
        @(posedge pclk);
        if (c) begin
            m_count = 0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            exp_q.delete();
        end else begin
            pop_ok  = r && (m_count > 0);
            push_ok = w && ((m_count < DEPTH) || pop_ok);
            if (r && m_count == 0) m_unf = 1'b1;
            if (w && !push_ok)     m_ovf = 1'b1;
            if (pop_ok)            m_count--;
            if (push_ok) begin
                m_count++;
                exp_q.push_back(wd);
            end
        end
        #1;
        check("level", 64'(level), 64'(m_count));
        check("flags", 64'(fifo_int),
              64'({m_count == DEPTH, m_count == 0, m_ovf, m_unf}));
        if (m_count > 0 && exp_q.size() > 0) check("head", 64'(rdata), 64'(exp_q[0]));
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        preset = 1'b1;
        wen    = 1'b0;
        wdata  = '0;
        ren    = 1'b0;
        clear  = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        preset = 1'b0;
        check("reset_level", 64'(level), 64'd0);
        check("reset_flags", 64'(fifo_int), 64'b0100);

        // First word falls through to rdata one cycle after the push.
        idle();
        step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        check("fwft_word", 64'(rdata), 64'hA5A5_0001);
        step(1'b0, '0, 1'b1, 1'b0);

        // Fill, overflow, drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        check("full_flag", 64'(fifo_int.fifo_full), 64'd1);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("overflow_flag", 64'(fifo_int.fifo_overflow), 64'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("drained_empty", 64'(fifo_int.fifo_empty), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Underflow is sticky through traffic until cleared.
        step(1'b0, '0, 1'b1, 1'b0);
        check("underflow_flag", 64'(fifo_int.fifo_underflow), 64'd1);
        for (int i = 0; i < 10; i++) step(1'b1, DW'(32'h200 + i), 1'b1, 1'b0);
        check("underflow_sticky", 64'(fifo_int.fifo_underflow), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("underflow_cleared", 64'(fifo_int.fifo_underflow), 64'd0);

        // Simultaneous push+pop while full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, DW'(32'h100 + k), 1'b1, 1'b0);
        check("full_pushpop_level", 64'(level), 64'(DEPTH));
        check("full_pushpop_no_ovf", 64'(fifo_int.fifo_overflow), 64'd0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Pointer wrap past the last slot.
        for (int i = 0; i < 40; i++) step(1'b1, DW'(32'h1000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, DW'(32'h2000 + i), 1'b0, 1'b0);
        check("wrap_level", 64'(level), 64'd40);
        check("wrap_not_full", 64'(fifo_int.fifo_full), 64'd0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Clear wins over a concurrent push and pop; the pushed word is discarded.
        step(1'b1, 32'h0BAD_0BAD, 1'b1, 1'b1);
        check("clear_level", 64'(level), 64'd0);
        check("clear_flags", 64'(fifo_int), 64'b0100);
        step(1'b1, 32'h0000_0077, 1'b0, 1'b0);
        check("after_clear_word", 64'(rdata), 64'h77);
        step(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic with phases biased toward filling and draining.
        for (int i = 0; i < 1600; i++) begin
            int wp, rp;
            case ((i / 200) % 4)
                0:       begin wp = 80; rp = 20; end
                1:       begin wp = 50; rp = 50; end
                2:       begin wp = 20; rp = 80; end
                default: begin wp = 60; rp = 60; end
            endcase
            step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp,
                 $urandom_range(0, 199) == 0);
        end

        while (m_count > 0) step(1'b0, '0, 1'b1, 1'b0);
        check("scoreboard_residual", 64'(exp_q.size()), 64'(level));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_fifo.md
Name: spi_fifo

Overview:
Synchronous single-clock FIFO used twice in the SPI APB peripheral.
- TX instance: the APB slave pushes (tfifo_wen); the shift datapath pops (tfifo_ren).
- RX instance: the shift datapath pushes (rfifo_wen); the APB slave pops (rfifo_ren).

It also supplies the per-FIFO occupancy for the status register and the full/empty/overflow/underflow flags for the interrupt register.

Parameters:
- DATA_WIDTH, 32 (SPI_DATA_WIDTH): word width.
- POINTER_WIDTH, 6 (SPI_POINTER_WIDTH): address bits.
- DEPTH, 2**POINTER_WIDTH (64): number of entries. Derived; not overridden independently.

Ports:
- pclk  in  1  peripheral clock; all state updates on the rising edge.
- preset  in  1  synchronous reset, active-high.
- wen  in  1  push strobe; one word per cycle.
- wdata  in  DATA_WIDTH  push data.
- ren  in  1  pop strobe; one word per cycle.
- rdata  out  DATA_WIDTH  head-of-queue word (first-word-fall-through).
- clear  in  1  synchronous flush (SPITXRST/SPIRXRST from the control register).
- level  out  POINTER_WIDTH+1  occupancy, 0..DEPTH.
- fifo_int  out  4  fifo_interrupt struct: {fifo_full, fifo_empty, fifo_overflow, fifo_underflow}.

Behaviour:
- Storage is DEPTH x DATA_WIDTH registers.
- Write and read pointers are POINTER_WIDTH+1 bits; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and wrap bits differ.
- Reset (preset=1) and clear=1 have identical effect:
  - both pointers 0, level=0, full=0, empty=1, overflow=0, underflow=0.
  - Memory contents are not cleared. rdata after reset is don't-care while empty.
- Priority: preset > clear > wen/ren. wen/ren in a clear cycle are discarded, and no flag is set.
- Push, not full: mem[wptr] <= wdata, wptr+1 (wraps 63->0 with the wrap bit toggling), level+1.
- Push when full, no pop: word dropped, pointers unchanged, overflow <= 1 (sticky).
- Pop, not empty: rptr+1, level-1.
  - rdata = mem[rptr] combinationally; it is valid whenever empty=0.
  - It updates to the next word the cycle after the pop.
- Pop when empty: no pointer change, underflow <= 1 (sticky). rdata is don't-care.
- Simultaneous push+pop:
  - Not empty, not full: both performed, level unchanged.
  - Full: both performed; the pop frees a slot, so the write is accepted. Level stays DEPTH; no overflow.
  - Empty: the pop is an underflow (flag set, ignored). The push is accepted, so level=1 next cycle and rdata=wdata.
- Flag timing:
  - full and empty are registered, derived from the post-update pointers, and valid the cycle after the edge.
  - overflow and underflow clear only on reset or clear.
- Status register mapping: SPITXST/SPIRXST (6 bits) = level[5:0]. level=64 reads as 0 there and is disambiguated by fifo_full.
- No combinational path from wen/ren to any output except through registered state.

Decomposition:
- Already in spi_package: SPI_DATA_WIDTH, SPI_POINTER_WIDTH, SPI_FIFO_DEPTH, bus, fifo_interrupt.
- No new typedefs are required.
- Single module with no sub-module. The memory array is inferred inside spi_fifo; a separate RAM wrapper is not warranted at 64x32.

Test Plan:
1. Reset, then idle:
   - level=0, fifo_int=4'b0100 (empty only).
   - Push 0xA5A5_0001 -> next cycle empty=0, level=1, rdata=0xA5A5_0001.
2. Push 0x0..0x3F (64 words) -> full=1, level=64.
   - 65th push 0xDEAD_BEEF -> overflow=1, level stays 64.
   - Pop 64 times -> rdata sequence 0x0..0x3F, then empty=1, with 0xDEAD_BEEF never seen.
3. From empty, pop -> underflow=1, level=0. Flag stays set through 10 push/pop cycles until clear=1.
4. Fill to 64, then push 0x100+pop together for 3 cycles:
   - level stays 64, no overflow.
   - Drain order continues 0x3..0x3F, then 0x100, 0x101, 0x102.
5. Push 40 words, pop 40, push 40 more (wraps the pointer past 63) -> data order preserved, level=40, full=0.
6. With level=20, assert clear together with wen and ren -> next cycle level=0, empty=1, overflow=underflow=0. The wen data is not stored.
